// File: rtl/cordic_atan2.sv
// cordic_atan2 -- iterative CORDIC vectoring engine.
// Rotates a signed (x, y) vector onto the +x axis one micro-rotation per
// clock and reports the accumulated angle atan2(y, x) and the scaled
// magnitude K*|v| (K ~= 1.64676, not compensated).
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   x_in, y_in          signed W-bit input vector
//   out_valid/out_ready output handshake; result held until accepted
//   theta               signed AW-bit binary angle, 2^(AW-1) codes = pi
//   mag                 unsigned W+1-bit magnitude times CORDIC gain
//   busy                high while rotating or holding a result
module cordic_atan2 #(
    parameter int W    = 16,
    parameter int ITER = 14,
    parameter int AW   = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x_in,
    input  logic [W-1:0]  y_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] theta,
    output logic [W:0]    mag,
    output logic          busy
);
    // Two guard bits: one for negating -2^(W-1), one for the CORDIC gain.
    localparam int XW = W + 2;
    localparam int IW = $clog2(ITER + 1);

    // atan(2^-i) in a 32-bit binary angle (2^31 codes = pi).
    function automatic logic [31:0] atan32(input int i);
        case (i)
            0:  atan32 = 32'd536870912;  1:  atan32 = 32'd316933406;
            2:  atan32 = 32'd167458907;  3:  atan32 = 32'd85004756;
            4:  atan32 = 32'd42667331;   5:  atan32 = 32'd21354465;
            6:  atan32 = 32'd10679838;   7:  atan32 = 32'd5340245;
            8:  atan32 = 32'd2670163;    9:  atan32 = 32'd1335087;
            10: atan32 = 32'd667544;     11: atan32 = 32'd333772;
            12: atan32 = 32'd166886;     13: atan32 = 32'd83443;
            14: atan32 = 32'd41722;      15: atan32 = 32'd20861;
            16: atan32 = 32'd10430;      17: atan32 = 32'd5215;
            18: atan32 = 32'd2608;       19: atan32 = 32'd1304;
            20: atan32 = 32'd652;        21: atan32 = 32'd326;
            22: atan32 = 32'd163;        23: atan32 = 32'd81;
            24: atan32 = 32'd41;         25: atan32 = 32'd20;
            26: atan32 = 32'd10;         27: atan32 = 32'd5;
            28: atan32 = 32'd3;          29: atan32 = 32'd1;
            30: atan32 = 32'd1;          default: atan32 = 32'd0;
        endcase
    endfunction

    // Round the 32-bit table down to AW bits once, at elaboration.
    function automatic logic [ITER-1:0][AW-1:0] build_tab();
        logic [32:0] r;
        int          sh;
        build_tab = '0;
        sh = 32 - AW;
        for (int i = 0; i < ITER; i++) begin
            r = {1'b0, atan32(i)} + ((33'd1 << sh) >> 1);
            r = r >> sh;
            build_tab[i] = r[AW-1:0];
        end
    endfunction

    localparam logic [ITER-1:0][AW-1:0] T_TAB = build_tab();

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [XW-1:0]  x_q, x_d, y_q, y_d;
    logic [AW-1:0]         z_q, z_d;
    logic [IW-1:0]         i_q, i_d;
    logic                  zero_q, zero_d;
    logic [AW-1:0]         theta_q, theta_d;
    logic [W:0]            mag_q, mag_d;

    logic signed [XW-1:0]  x_ext, y_ext, x_sh, y_sh;
    logic [AW-1:0]         t_i;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        theta_d = theta_q;
        mag_d   = mag_q;
        x_ext   = {{2{x_in[W-1]}}, x_in};
        y_ext   = {{2{y_in[W-1]}}, y_in};
        x_sh    = x_q >>> i_q;
        y_sh    = y_q >>> i_q;
        t_i     = T_TAB[i_q];
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ROTATE;
                    i_d     = '0;
                    zero_d  = (x_in == '0) && (y_in == '0);
                    // Left half-plane: rotate by pi so the loop only ever
                    // has to cover (-pi/2, pi/2).
                    if (x_in[W-1]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = {1'b1, {(AW-1){1'b0}}};
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end
                end
            end
            ROTATE: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + t_i;
                end else begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - t_i;
                end
                i_d = i_q + IW'(1);
                if (i_q == IW'(ITER - 1)) begin
                    state_d = DONE;
                    // A zero vector still accumulates z; report 0 instead.
                    theta_d = zero_q ? '0 : z_d;
                    mag_d   = x_d[W:0];
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= 1'b0;
            theta_q <= '0;
            mag_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            theta_q <= theta_d;
            mag_q   <= mag_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign theta     = theta_q;
    assign mag       = mag_q;

endmodule
